// File: rtl/core_pkg.sv
// core_pkg: shared core widths, constants and the fetch-entry type.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of fetched {pc, inst} entries; head reads as zero when empty.
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count < CW'(DEPTH) || do_pop);
  assign head = count != '0 ? mem[rd] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencing, one-cycle memory request tracking and redirect handling feeding fetch_buffer.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [XLEN-1:0] pc_q, req_pc_q;
  logic inflight_q, pop, issue;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head;
  assign imem_addr = pc_q;
  assign pop = out_valid & out_ready;
  // Occupancy counts the word still in flight so the buffer can never overflow.
  assign occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = !redirect_valid && occ < (CW+1)'(BUF_DEPTH);
  assign out_valid = count != '0;
  assign out_pc = head.pc;
  assign out_inst = head.inst;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= {RESET_PC[31:2], 2'b00};
      req_pc_q <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q <= pc_q + 32'd4;
      end
    end
  end
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .push(inflight_q & ~redirect_valid),
    .pop(pop & ~redirect_valid),
    .flush(redirect_valid),
    .din('{pc: req_pc_q, inst: imem_inst}),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of inst_fetch against a one-cycle instruction memory model.
module tb_inst_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] imem_addr, imem_inst = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_inst;
  int tests = 0;
  int fails = 0;
  inst_fetch dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );
  always #5 clk = ~clk;
  always @(posedge clk) imem_inst <= imem_addr ^ K;
  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "timeout");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, pc ^ K);
  endtask
  task automatic restart();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    reset = 1'b0;
    step();
    chk("lat_valid1", 32'(out_valid), 32'd0);
    step();
    chk_out("seq0", 32'h0);
    chk("seq_addr", imem_addr, 32'h8);
    step();
    chk_out("seq4", 32'h4);
    step();
    chk_out("seq8", 32'h8);
    step();
    chk_out("seqc", 32'hC);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("rel_valid", 32'(out_valid), 32'd0);
    step();
    chk_out("stall_first", 32'h0);
    out_ready = 1'b0;
    #1 chk("stall_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out("stall_hold", 32'h0);
      chk("stall_addr", imem_addr, 32'h8);
    end
    chk("stall_count", 32'(dut.count), 32'd2);
    out_ready = 1'b1;
    #1 chk_out("rel0", 32'h0);
    step();
    chk_out("rel4", 32'h4);
    step();
    chk_out("rel8", 32'h8);
    step();
    chk_out("relc", 32'hC);
    restart();
    step();
    step();
    chk_out("rd_first", 32'h0);
    out_ready = 1'b0;
    step();
    chk("rd_count", 32'(dut.count), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h26;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h24);
    step();
    chk("rd_valid2", 32'(out_valid), 32'd0);
    step();
    chk_out("rd24", 32'h24);
    step();
    chk_out("rd28", 32'h28);
    step();
    chk_out("rd2c", 32'h2C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_pc = 32'h80;
    chk("b2b_valid1", 32'(out_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("b2b_valid2", 32'(out_valid), 32'd0);
    chk("b2b_addr", imem_addr, 32'h80);
    step();
    chk("b2b_valid3", 32'(out_valid), 32'd0);
    step();
    chk_out("b2b80", 32'h80);
    step();
    chk_out("b2b84", 32'h84);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    step();
    chk_out("wrap_f8", 32'hFFFF_FFF8);
    chk("wrap_inst_lit", out_inst, 32'h5A5A_FFF8);
    step();
    chk_out("wrap_fc", 32'hFFFF_FFFC);
    step();
    chk_out("wrap_0", 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC fetched first after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: output buffer entries; legal values 2 only.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_addr  out  32  byte address to instruction memory; memory returns the word one cycle later.
REQ-006 SHALL have port imem_inst  in  32  instruction word for the address driven in the previous cycle.
REQ-007 SHALL have port redirect_valid  in  1  branch/jump taken; flush and refetch.
REQ-008 SHALL have port redirect_pc  in  32  redirect target address.
REQ-009 SHALL have port out_valid  out  1  buffered instruction available to decode.
REQ-010 SHALL have port out_ready  in  1  decode accepts head entry this cycle.
REQ-011 SHALL have port out_pc  out  32  PC of head entry.
REQ-012 SHALL have port out_inst  out  32  instruction word of head entry.

Function
REQ-013 SHALL drive imem_addr = pc_q combinationally from the fetch PC register; bits [1:0] always 0.
REQ-014 SHALL issue a request in a cycle iff no redirect and count_q + inflight_q - pop < BUF_DEPTH, where pop = out_valid & out_ready.
REQ-015 On issue, SHALL set inflight_q=1, record req_pc_q=pc_q, and advance pc_q by 4 (modulo 2^32, 0xFFFF_FFFC wraps to 0x0); without issue, inflight_q=0 and pc_q holds.
REQ-016 When inflight_q=1, SHALL push {req_pc_q, imem_inst} into the buffer tail that cycle.
REQ-017 SHALL assert out_valid iff count_q != 0; out_pc/out_inst SHALL show the head entry and be 0 when empty.
REQ-018 Push and pop in the same cycle SHALL leave count_q unchanged; buffer SHALL never overflow or drop an entry.
REQ-019 Sustained throughput SHALL be one instruction per cycle with out_ready held high; first-request-to-out_valid latency SHALL be 2 cycles.
REQ-020 With out_ready low, out_valid/out_pc/out_inst SHALL remain stable until accepted.
REQ-021 On redirect_valid, SHALL at the next edge set pc_q = {redirect_pc[31:2], 2'b00}, clear count_q, clear inflight_q (discard returning word), and issue nothing that cycle.
REQ-022 Redirect SHALL take priority over push and pop in the same cycle; a pop coinciding with redirect counts as accepted by decode.
REQ-023 Back-to-back redirects SHALL each restart fetch; the last one wins.
REQ-024 First out_pc after a redirect SHALL be the aligned target, 2 cycles after out_valid drops.

Reset
REQ-025 Asserting reset SHALL immediately force pc_q=RESET_PC, count_q=0, inflight_q=0, buffer contents 0, hence out_valid=0, out_pc=0, out_inst=0, imem_addr=RESET_PC.
REQ-026 imem_inst SHALL be ignored while reset is high; first request issues in the first cycle after reset deasserts.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight instructions with no partial output.

Structure
REQ-028 XLEN=32, INST_NOP=32'h0000_0013 and the {pc, inst} fetch-entry struct SHALL live in shared package core_pkg.
REQ-029 Buffer SHALL be sub-module fetch_buffer (BUF_DEPTH-entry FIFO with push, pop, flush, count); PC, issue and redirect logic stay in inst_fetch.

Verification
REQ-030 Reset release, out_ready=1, memory model returns inst=addr^32'hA5A5_0000 -> out_valid from cycle 2, out_pc 0x0,0x4,0x8,0xC on consecutive cycles, out_inst matching.
REQ-031 out_ready=0 for 6 cycles after first valid -> out_pc held 0x0, count_q never exceeds 2, imem_addr stalls at 0x8; release -> 0x0,0x4,0x8,0xC with no gap or duplicate.
REQ-032 redirect_valid with redirect_pc=0x26 while 2 entries buffered -> next cycle out_valid=0, imem_addr=0x24; out_pc=0x24 two cycles later; 0x4/0x8 never appear afterwards.
REQ-033 Redirect to 0x40 then 0x80 on consecutive cycles, coinciding with a pop -> no 0x40 entry output; first out_pc=0x80.
REQ-034 Redirect to 0xFFFF_FFF8 -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-035 reset asserted between clock edges mid-stream -> out_valid=0 and imem_addr=RESET_PC before next edge; refetch restarts at 0x0 after release.
